// File: rtl/npc_pkg.sv
// Shared NPC core definitions: RV32I opcodes, ALU encodings,
// immediate formats and the decode-stage control bundle.
package npc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_COPYB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } idu_state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    logic       alu_bsrc;
    logic       alu_asrc;
    logic       pca_src;
    logic       pcb_src;
    logic       branch;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic [2:0] mem_width;
    logic       ebreak;
    logic       illegal;
  } idu_ctrl_t;

  // alt selects SUB/SRA; callers gate it for OP-IMM
  function automatic alu_op_e f3_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_decode_if.sv
// Fetch-to-decode and decode-to-execute handshakes plus the
// decoded bundle presented to execute.
interface idu_decode_if #(
  parameter int XLEN = 32
);

  logic            ifu_valid;
  logic [31:0]     ifu_inst;
  logic [XLEN-1:0] ifu_pc;
  logic            idu_ready;

  logic            exu_valid;
  logic            exu_ready;
  logic [XLEN-1:0] pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [31:0]     imm;
  logic [3:0]      alu_op;
  logic            alu_bsrc;
  logic            alu_asrc;
  logic            pca_src;
  logic            pcb_src;
  logic            branch;
  logic            reg_wen;
  logic            mem_ren;
  logic            mem_wen;
  logic [2:0]      mem_width;
  logic            ebreak;
  logic            illegal;

  modport slave (
    input  ifu_valid,
    input  ifu_inst,
    input  ifu_pc,
    output idu_ready,
    output exu_valid,
    input  exu_ready,
    output pc,
    output rs1_addr,
    output rs2_addr,
    output rd_addr,
    output imm,
    output alu_op,
    output alu_bsrc,
    output alu_asrc,
    output pca_src,
    output pcb_src,
    output branch,
    output reg_wen,
    output mem_ren,
    output mem_wen,
    output mem_width,
    output ebreak,
    output illegal
  );

  modport master (
    output ifu_valid,
    output ifu_inst,
    output ifu_pc,
    input  idu_ready,
    input  exu_valid,
    output exu_ready,
    input  pc,
    input  rs1_addr,
    input  rs2_addr,
    input  rd_addr,
    input  imm,
    input  alu_op,
    input  alu_bsrc,
    input  alu_asrc,
    input  pca_src,
    input  pcb_src,
    input  branch,
    input  reg_wen,
    input  mem_ren,
    input  mem_wen,
    input  mem_width,
    input  ebreak,
    input  illegal
  );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate extraction; every format sign-extends from
// inst[31]. Formats without an immediate yield zero.
module imm_gen
  import npc_pkg::*;
(
  input  logic [31:0] inst_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  logic unused_opc;
  assign unused_opc = ^inst_i[6:0];

  logic s;
  assign s = inst_i[31];

  always_comb begin
    imm_o = '0;
    unique case (fmt_i)
      IMM_I: imm_o = {{20{s}}, inst_i[31:20]};
      IMM_S: imm_o = {{20{s}}, inst_i[31:25],
                      inst_i[11:7]};
      IMM_B: imm_o = {{19{s}}, s, inst_i[7],
                      inst_i[30:25], inst_i[11:8],
                      1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{s}}, s, inst_i[19:12],
                      inst_i[20], inst_i[30:21],
                      1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/idu_decode.sv
// Decode stage: RV32I decode into a one-entry output register
// with valid/ready handshakes on both sides.
module idu_decode
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  idu_decode_if.slave bus
);

  idu_state_e      state_q;
  idu_ctrl_t       ctrl_q;
  idu_ctrl_t       ctrl_d;
  logic [31:0]     imm_q;
  logic [31:0]     imm_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  imm_fmt_e        fmt;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        full;
  logic        ready;
  logic        accept;
  logic        drain;

  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;
  logic is_br;
  logic is_ld;
  logic is_st;
  logic is_opi;
  logic is_op;
  logic is_ebreak;

  assign inst = bus.ifu_inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign pc_d = bus.ifu_pc;

  assign is_lui    = opc == OP_LUI;
  assign is_auipc  = opc == OP_AUIPC;
  assign is_jal    = opc == OP_JAL;
  assign is_jalr   = opc == OP_JALR;
  assign is_br     = opc == OP_BRANCH;
  assign is_ld     = opc == OP_LOAD;
  assign is_st     = opc == OP_STORE;
  assign is_opi    = opc == OP_IMM;
  assign is_op     = opc == OP_OP;
  assign is_ebreak = inst == INST_EBREAK;

  always_comb begin
    ctrl_d     = '0;
    fmt        = IMM_NONE;
    ctrl_d.rs1 = inst[19:15];
    ctrl_d.rs2 = inst[24:20];
    ctrl_d.rd  = inst[11:7];
    unique case (1'b1)
      is_lui: begin
        fmt             = IMM_U;
        ctrl_d.alu_op   = ALU_COPYB;
        ctrl_d.alu_bsrc = 1'b1;
        ctrl_d.reg_wen  = 1'b1;
      end
      is_auipc: begin
        fmt             = IMM_U;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.alu_bsrc = 1'b1;
        ctrl_d.reg_wen  = 1'b1;
      end
      // link value pc+4 is formed in EXU from operand A
      is_jal: begin
        fmt             = IMM_J;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.pca_src  = 1'b1;
        ctrl_d.reg_wen  = 1'b1;
      end
      is_jalr: begin
        fmt             = IMM_I;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.pca_src  = 1'b1;
        ctrl_d.pcb_src  = 1'b1;
        ctrl_d.reg_wen  = 1'b1;
      end
      is_br: begin
        fmt              = IMM_B;
        ctrl_d.alu_op    = ALU_SUB;
        ctrl_d.branch    = 1'b1;
        ctrl_d.mem_width = f3;
      end
      is_ld: begin
        fmt              = IMM_I;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.alu_bsrc  = 1'b1;
        ctrl_d.mem_ren   = 1'b1;
        ctrl_d.reg_wen   = 1'b1;
        ctrl_d.mem_width = f3;
      end
      is_st: begin
        fmt              = IMM_S;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.alu_bsrc  = 1'b1;
        ctrl_d.mem_wen   = 1'b1;
        ctrl_d.mem_width = f3;
      end
      is_opi: begin
        fmt             = IMM_I;
        ctrl_d.alu_op   = f3_alu(f3,
                            (f3 == 3'b101) & inst[30]);
        ctrl_d.alu_bsrc = 1'b1;
        ctrl_d.reg_wen  = 1'b1;
      end
      is_op: begin
        ctrl_d.alu_op  = f3_alu(f3, inst[30]);
        ctrl_d.reg_wen = 1'b1;
      end
      is_ebreak: ctrl_d.ebreak = 1'b1;
      default:   ctrl_d.illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .inst_i (inst),
    .fmt_i  (fmt),
    .imm_o  (imm_d)
  );

  assign full   = state_q == S_FULL;
  assign ready  = !full || bus.exu_ready;
  assign accept = bus.ifu_valid && ready;
  assign drain  = full && bus.exu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (accept) begin
      state_q <= S_FULL;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end else if (drain) begin
      state_q <= S_EMPTY;
    end
  end

  assign bus.idu_ready = ready;
  assign bus.exu_valid = full;
  assign bus.pc        = pc_q;
  assign bus.imm       = imm_q;
  assign bus.rs1_addr  = ctrl_q.rs1;
  assign bus.rs2_addr  = ctrl_q.rs2;
  assign bus.rd_addr   = ctrl_q.rd;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.alu_bsrc  = ctrl_q.alu_bsrc;
  assign bus.alu_asrc  = ctrl_q.alu_asrc;
  assign bus.pca_src   = ctrl_q.pca_src;
  assign bus.pcb_src   = ctrl_q.pcb_src;
  assign bus.branch    = ctrl_q.branch;
  assign bus.reg_wen   = ctrl_q.reg_wen;
  assign bus.mem_ren   = ctrl_q.mem_ren;
  assign bus.mem_wen   = ctrl_q.mem_wen;
  assign bus.mem_width = ctrl_q.mem_width;
  assign bus.ebreak    = ctrl_q.ebreak;
  assign bus.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_idu_decode.sv
// Bench for idu_decode: directed scenarios, then random traffic
// checked every cycle against a behavioural decode model.
module tb_idu_decode;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idu_decode_if #(.XLEN(XLEN)) bus ();

  idu_decode #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        asrc;
    logic        bsrc;
    logic        pca;
    logic        pcb;
    logic        br;
    logic        wen;
    logic        ren;
    logic        sen;
    logic [2:0]  w;
    logic        eb;
    logic        ill;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  // ALU codes by name order: ADD SLL SLT SLTU XOR SRL OR AND
  function automatic logic [3:0] f3_code(logic [2:0] f3);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    return tbl[f3];
  endfunction

  function automatic exp_t ref_decode(logic [31:0] i,
                                      logic [31:0] p);
    exp_t e;
    int   v;
    e     = '0;
    v     = 0;
    e.pc  = p;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    case (i[6:0])
      7'h37: begin
        v = int'(i & 32'hFFFF_F000);
        e.alu = 4'd10; e.bsrc = 1; e.wen = 1;
      end
      7'h17: begin
        v = int'(i & 32'hFFFF_F000);
        e.asrc = 1; e.bsrc = 1; e.wen = 1;
      end
      7'h6F: begin
        v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
          + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        e.pca = 1; e.asrc = 1; e.wen = 1;
      end
      7'h67: begin
        v = int'($signed(i)) >>> 20;
        e.pca = 1; e.pcb = 1; e.asrc = 1; e.wen = 1;
      end
      7'h63: begin
        v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
          + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        e.br = 1; e.alu = 4'd1; e.w = i[14:12];
      end
      7'h03: begin
        v = int'($signed(i)) >>> 20;
        e.ren = 1; e.wen = 1; e.bsrc = 1; e.w = i[14:12];
      end
      7'h23: begin
        v = ((int'($signed(i)) >>> 25) * 32) + int'(i[11:7]);
        e.sen = 1; e.bsrc = 1; e.w = i[14:12];
      end
      7'h13: begin
        v = int'($signed(i)) >>> 20;
        e.alu = (i[14:12] == 3'd5 && i[30]) ? 4'd7
                                            : f3_code(i[14:12]);
        e.bsrc = 1; e.wen = 1;
      end
      7'h33: begin
        if (i[14:12] == 3'd0 && i[30]) e.alu = 4'd1;
        else if (i[14:12] == 3'd5 && i[30]) e.alu = 4'd7;
        else e.alu = f3_code(i[14:12]);
        e.wen = 1;
      end
      default: begin
        if (i == 32'h0010_0073) e.eb = 1;
        else e.ill = 1;
      end
    endcase
    e.imm = 32'(v);
    return e;
  endfunction

  function automatic logic [16:0] ctrl_of(exp_t e);
    return {e.alu, e.asrc, e.bsrc, e.pca, e.pcb, e.br,
            e.wen, e.ren, e.sen, e.w, e.eb, e.ill};
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {bus.alu_op, bus.alu_asrc, bus.alu_bsrc,
            bus.pca_src, bus.pcb_src, bus.branch,
            bus.reg_wen, bus.mem_ren, bus.mem_wen,
            bus.mem_width, bus.ebreak, bus.illegal};
  endfunction

  // Reference: one slot, full or empty, plus its expected bundle
  logic m_full = 1'b0;
  exp_t m_exp  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_full <= 1'b0;
    end else if (bus.ifu_valid && (!m_full || bus.exu_ready)) begin
      m_full <= 1'b1;
      m_exp  <= ref_decode(bus.ifu_inst, bus.ifu_pc);
    end else if (m_full && bus.exu_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("exu_valid", 32'(bus.exu_valid), 32'(m_full));
    chk("idu_ready", 32'(bus.idu_ready),
        32'(!m_full || bus.exu_ready));
    if (m_full) begin
      chk("pc", bus.pc, m_exp.pc);
      chk("imm", bus.imm, m_exp.imm);
      chk("regs", 32'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr}),
          32'({m_exp.rs1, m_exp.rs2, m_exp.rd}));
      chk("ctrl", 32'(dut_ctrl()), 32'(ctrl_of(m_exp)));
    end
  end

  task automatic drive(logic v, logic [31:0] i,
                       logic [31:0] p, logic r);
    bus.ifu_valid = v;
    bus.ifu_inst  = i;
    bus.ifu_pc    = p;
    bus.exu_ready = r;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0F};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return 32'h0010_0073;
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    drive(0, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.exu_valid), 32'd0);
    chk("rst_ready", 32'(bus.idu_ready), 32'd1);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    chk("rst_bundle", 32'({bus.rs1_addr, bus.rs2_addr,
        bus.rd_addr}) | 32'(dut_ctrl()), 32'd0);

    // addi x5,x0,-1
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 32'hFFF0_0293, 32'h8000_0000, 0);
    @(posedge clk); #1;
    bus.ifu_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", 32'(bus.exu_valid), 32'd1);
    chk("addi_rd", 32'(bus.rd_addr), 32'd5);
    chk("addi_rs1", 32'(bus.rs1_addr), 32'd0);
    chk("addi_imm", bus.imm, 32'hFFFF_FFFF);
    chk("addi_alu", 32'(bus.alu_op), 32'd0);
    chk("addi_ctl", 32'({bus.alu_bsrc, bus.reg_wen,
        bus.pca_src, bus.pcb_src}), 32'b1100);
    chk("model_addi_imm", m_exp.imm, 32'hFFFF_FFFF);

    // jal x1,-8 waits behind a stalled execute
    @(posedge clk); #1;
    drive(1, 32'hFF9F_F0EF, 32'h8000_0004, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.idu_ready), 32'd0);
      chk("bp_hold_rd", 32'(bus.rd_addr), 32'd5);
      chk("bp_hold_pc", bus.pc, 32'h8000_0000);
    end
    @(posedge clk); #1;
    bus.exu_ready = 1'b1;
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("jal_valid", 32'(bus.exu_valid), 32'd1);
    chk("jal_pc", bus.pc, 32'h8000_0004);
    chk("jal_imm", bus.imm, 32'hFFFF_FFF8);
    chk("jal_ctl", 32'({bus.pca_src, bus.pcb_src,
        bus.reg_wen}), 32'b101);
    chk("jal_rd", 32'(bus.rd_addr), 32'd1);
    chk("model_jal_imm", m_exp.imm, 32'hFFFF_FFF8);

    @(posedge clk); #1;
    drive(1, 32'h0000_007F, 32'h8000_0010, 1);
    @(posedge clk); #1;
    drive(1, 32'h0010_0073, 32'h8000_0014, 1);
    @(negedge clk);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_en", 32'({bus.reg_wen, bus.mem_ren,
        bus.mem_wen}), 32'd0);
    chk("model_ill", 32'(m_exp.ill), 32'd1);
    @(posedge clk); #1;
    drive(1, 32'h00A0_0513, 32'h8000_0018, 1);
    @(negedge clk);
    chk("ebreak_flag", 32'(bus.ebreak), 32'd1);
    chk("ebreak_ill", 32'(bus.illegal), 32'd0);

    // reset lands on a simultaneous accept and drain
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 32'h0010_0093, 32'h8000_001C, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.exu_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.idu_ready), 32'd1);
    @(negedge clk);
    chk("rst_mid_nofwd", 32'(bus.exu_valid), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, rand_inst(),
            $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
